frequency_generator: RTL and testbench

FREQUENCY_GENERATOR -- requirements
Module: frequency_generator

---
 rtl/frequency_generator_pkg.sv | 13 +
 rtl/frequency_generator_if.sv | 25 ++
 rtl/frequency_generator_phase_counter.sv | 37 +++
 rtl/frequency_generator.sv | 90 +++++++++
 tb/tb_frequency_generator.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/frequency_generator_pkg.sv
// Shared definitions for the frequency generator and its companion measurement block.
// Holds the waveform FSM state encoding and the default length width.
package frequency_generator_pkg;

    localparam int FG_DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } fg_state_e;

endpackage

// File: rtl/frequency_generator_if.sv
// Control/status bundle of the frequency generator.
// The master drives the configuration; the slave (the generator) drives the waveform.
interface frequency_generator_if
    import frequency_generator_pkg::*;
#(
    parameter int WIDTH = FG_DEFAULT_WIDTH
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] on_len;
    logic [WIDTH-1:0] off_len;
    logic             OUT;
    logic             period_done;
    logic             busy;

    modport master (
        output enable, load, on_len, off_len,
        input  OUT, period_done, busy
    );

    modport slave (
        input  enable, load, on_len, off_len,
        output OUT, period_done, busy
    );
endinterface

// File: rtl/frequency_generator_phase_counter.sv
// Loadable down-counter that times one waveform phase.
// Load takes priority over decrement; the count saturates at zero.
module phase_counter
    import frequency_generator_pkg::*;
#(
    parameter int WIDTH = FG_DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec_en,
    output logic             zero
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_en) begin
            count_d = load_val;
        end else if (dec_en && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);
endmodule

// File: rtl/frequency_generator.sv
// Programmable on/off waveform generator with double-buffered phase lengths.
// New lengths are adopted while idle or exactly at a period boundary.
module frequency_generator
    import frequency_generator_pkg::*;
#(
    parameter int WIDTH = FG_DEFAULT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    frequency_generator_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    fg_state_e        state_q, state_d;
    logic [WIDTH-1:0] pend_on_q, pend_on_d, pend_off_q, pend_off_d;
    logic [WIDTH-1:0] act_on_q, act_on_d, act_off_q, act_off_d;
    logic             out_q, out_d;
    logic [WIDTH-1:0] cfg_on, cfg_off, cnt_load_val;
    logic             cnt_load, cnt_dec, cnt_zero, period_end;

    phase_counter #(.WIDTH(WIDTH)) u_phase_counter (
        .CLK      (CLK),
        .RST      (RST),
        .load_en  (cnt_load),
        .load_val (cnt_load_val),
        .dec_en   (cnt_dec),
        .zero     (cnt_zero)
    );

    // A load strobe bypasses the pending registers so a load on a boundary governs the next period.
    assign cfg_on     = bus.load ? bus.on_len  : pend_on_q;
    assign cfg_off    = bus.load ? bus.off_len : pend_off_q;
    assign period_end = ((state_q == HIGH) && cnt_zero && (act_off_q == '0)) ||
                        ((state_q == LOW)  && cnt_zero);

    always_comb begin
        state_d      = state_q;
        pend_on_d    = cfg_on;
        pend_off_d   = cfg_off;
        act_on_d     = act_on_q;
        act_off_d    = act_off_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        if ((state_q == IDLE) || period_end) begin
            act_on_d  = cfg_on;
            act_off_d = cfg_off;
            state_d   = IDLE;
            if (bus.enable && ((cfg_on != '0) || (cfg_off != '0))) begin
                cnt_load = 1'b1;
                if (cfg_on != '0) begin
                    state_d      = HIGH;
                    cnt_load_val = cfg_on - ONE;
                end else begin
                    state_d      = LOW;
                    cnt_load_val = cfg_off - ONE;
                end
            end
        end else if ((state_q == HIGH) && cnt_zero) begin
            state_d      = LOW;
            cnt_load     = 1'b1;
            cnt_load_val = act_off_q - ONE;
        end else begin
            cnt_dec = 1'b1;
        end
        out_d = (state_d == HIGH);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            pend_on_q  <= '0;
            pend_off_q <= '0;
            act_on_q   <= '0;
            act_off_q  <= '0;
            out_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_on_q  <= pend_on_d;
            pend_off_q <= pend_off_d;
            act_on_q   <= act_on_d;
            act_off_q  <= act_off_d;
            out_q      <= out_d;
        end
    end

    assign bus.OUT         = out_q;
    assign bus.period_done = period_end;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_frequency_generator.sv
// Self-checking bench: every cycle compares OUT/period_done/busy against a
// queue-based period schedule built from the requested lengths.
module tb_frequency_generator;
    localparam int W = 8;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    frequency_generator_if #(.WIDTH(W)) bus();

    frequency_generator #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned m_pend_on, m_pend_off;
    bit          m_sched[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend_on  = 0;
        m_pend_off = 0;
        m_sched.delete();
    endtask

    // One clock edge of the reference: a period is a list of samples, 1s then 0s.
    task automatic model_edge(input bit en, input bit ld, input int unsigned on,
                              input int unsigned off, input bit rst);
        int unsigned c_on, c_off;
        if (rst) begin
            model_reset();
            return;
        end
        c_on       = ld ? on  : m_pend_on;
        c_off      = ld ? off : m_pend_off;
        m_pend_on  = c_on;
        m_pend_off = c_off;
        if (m_sched.size() > 0) void'(m_sched.pop_front());
        if ((m_sched.size() == 0) && en && ((c_on + c_off) != 0)) begin
            for (int i = 0; i < int'(c_on); i++)  m_sched.push_back(1'b1);
            for (int i = 0; i < int'(c_off); i++) m_sched.push_back(1'b0);
        end
    endtask

    task automatic check_outputs(input string tag);
        bit e_out, e_pd, e_busy;
        e_out  = (m_sched.size() > 0) ? m_sched[0] : 1'b0;
        e_pd   = (m_sched.size() == 1);
        e_busy = (m_sched.size() > 0);
        check_val({tag, "_out"},  32'(bus.OUT),         32'(e_out));
        check_val({tag, "_pd"},   32'(bus.period_done), 32'(e_pd));
        check_val({tag, "_busy"}, 32'(bus.busy),        32'(e_busy));
    endtask

    task automatic step(input string tag);
        bit en, ld, r;
        int unsigned on, off;
        en  = bus.enable;
        ld  = bus.load;
        r   = RST;
        on  = bus.on_len;
        off = bus.off_len;
        @(posedge CLK);
        model_edge(en, ld, on, off, r);
        #1;
        check_outputs(tag);
        bus.load = 1'b0;
    endtask

    task automatic do_load(input int unsigned on, input int unsigned off);
        bus.on_len  = W'(on);
        bus.off_len = W'(off);
        bus.load    = 1'b1;
        $display("load on=%0d off=%0d enable=%0b at %0t", on, off, bus.enable, $time);
    endtask

    task automatic wait_idle();
        int guard;
        bus.enable = 1'b0;
        guard = 0;
        while ((m_sched.size() != 0) && (guard < 600)) begin
            step("drain");
            guard++;
        end
        check_val("drain_bound", 32'(m_sched.size()), 32'd0);
    endtask

    initial begin
        RST         = 1'b1;
        bus.enable  = 1'b0;
        bus.load    = 1'b0;
        bus.on_len  = '0;
        bus.off_len = '0;
        model_reset();
        #1;
        check_outputs("reset");
        step("reset_hold");
        step("reset_hold");
        RST = 1'b0;

        do_load(3, 2);
        bus.enable = 1'b1;
        repeat (15) step("on3_off2");

        wait_idle();
        do_load(4, 0);
        bus.enable = 1'b1;
        repeat (12) step("on4_off0");

        wait_idle();
        do_load(2, 2);
        bus.enable = 1'b1;
        step("midload_start");
        do_load(1, 3);
        repeat (12) step("midload");

        wait_idle();
        do_load(3, 3);
        bus.enable = 1'b1;
        repeat (4) step("drop_en_run");
        bus.enable = 1'b0;
        $display("enable dropped on first LOW cycle at %0t", $time);
        repeat (6) step("drop_en_finish");

        wait_idle();
        do_load(5, 5);
        bus.enable = 1'b1;
        repeat (2) step("pre_rst");
        RST = 1'b1;
        model_reset();
        $display("async reset asserted during HIGH at %0t", $time);
        #1;
        check_outputs("async_rst");
        step("rst_hold");
        RST = 1'b0;
        bus.enable = 1'b1;
        repeat (10) step("post_rst_noload");

        do_load(0, 0);
        repeat (20) step("zero_cfg");

        wait_idle();
        do_load(255, 1);
        bus.enable = 1'b1;
        repeat (260) step("max_len");

        wait_idle();
        for (int i = 0; i < 400; i++) begin
            bus.enable = ($urandom % 8) != 0;
            if (($urandom % 6) == 0) do_load($urandom_range(0, 4), $urandom_range(0, 4));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
